// File: rtl/cam_frame_writer.sv
// cam_frame_writer: decimating, mirrorable camera-to-frame-buffer write path
module cam_frame_writer #(
    parameter int SRC_W = 640,
    parameter int SRC_H = 480,
    parameter int SHIFT = 2,
    parameter int DW    = 16,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          line_end,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    input  logic          mirror_x,
    input  logic          flip_y,
    input  logic          gray_mode,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          frame_done,
    output logic [7:0]    frame_count,
    output logic          clip_err,
    output logic          busy
);
    localparam int DST_W = SRC_W >> SHIFT;
    localparam int DST_H = SRC_H >> SHIFT;
    localparam int CW    = $clog2(SRC_W + 1);
    localparam int RW    = $clog2(SRC_H + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          mx, fy, gm;
    logic          act, in_range, pix_ok, pix_drop, keep;
    logic          le, last_row, row_over, short_frame, done_n;
    logic [AW-1:0] x, y, xd, yd, addr_n;
    logic [DW-1:0] gray_px, data_n;

    // pixel/line events only count in ACTIVE and lose to a same-cycle frame_start
    assign act         = (state == ACTIVE) && !frame_start;
    assign in_range    = (col < CW'(SRC_W)) && (row < RW'(SRC_H));
    assign pix_ok      = act && pix_valid && in_range;
    assign pix_drop    = act && pix_valid && !in_range;
    assign keep        = pix_ok && (col[SHIFT-1:0] == '0) && (row[SHIFT-1:0] == '0);
    assign le          = act && line_end;
    assign last_row    = le && (row == RW'(SRC_H - 1));
    assign row_over    = le && (row == RW'(SRC_H));
    assign short_frame = (state == ACTIVE) && frame_start;
    assign done_n      = short_frame || last_row;
    assign busy        = (state == ACTIVE);
    assign data_n      = gm ? gray_px : pix_data;

    // frame sequencing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // any frame_start opens a frame; closing the last row parks in WAIT
    always_comb begin
        state_n = state;
        if (frame_start)   state_n = ACTIVE;
        else if (last_row) state_n = WAIT;
    end

    // destination address: mirror/flip then y*DST_W+x as shift-adds of the constant
    always_comb begin
        x      = AW'(col >> SHIFT);
        y      = AW'(row >> SHIFT);
        xd     = mx ? AW'(DST_W - 1) - x : x;
        yd     = fy ? AW'(DST_H - 1) - y : y;
        addr_n = xd;
        for (int i = 0; i < AW; i++)
            if (DST_W[i]) addr_n = addr_n + (yd << i);
    end

    generate
        if (DW == 16) begin : g_gray
            logic [5:0] g;
            // RGB565 luma approximation (R + 2G + B)/4 on 6-bit channels, replicated back
            always_comb begin
                g = 6'(({2'b00, pix_data[15:11], pix_data[15]}
                      + {1'b0, pix_data[10:5], 1'b0}
                      + {2'b00, pix_data[4:0], pix_data[4]}) >> 2);
                gray_px = {g[5:1], g, g[5:1]};
            end
        end else begin : g_pass
            assign gray_px = pix_data;
        end
    endgenerate

    // source position counters and per-frame mode latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            mx  <= 1'b0;
            fy  <= 1'b0;
            gm  <= 1'b0;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
            mx  <= mirror_x;
            fy  <= flip_y;
            gm  <= gray_mode;
        end else if (le) begin
            col <= '0;
            row <= (row == RW'(SRC_H)) ? row : row + RW'(1);
        end else if (act && pix_valid && col != CW'(SRC_W)) begin
            col <= col + CW'(1);
        end
    end

    // registered buffer write port, one strobe per kept sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= keep;
            if (keep) begin
                waddr <= addr_n;
                wdata <= data_n;
            end
        end
    end

    // frame completion pulse, frame counter and sticky clipping flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            clip_err    <= 1'b0;
        end else begin
            frame_done <= done_n;
            if (done_n) frame_count <= frame_count + 8'd1;
            if (frame_start)                clip_err <= short_frame;
            else if (pix_drop || row_over)  clip_err <= 1'b1;
        end
    end
endmodule
